// File: rtl/lm_sm_seq_pkg.sv
// Shared definitions for the load/store-multiple sequencer:
// FSM state encoding and the data, address, mask and index widths.
package lm_sm_seq_pkg;

    localparam int unsigned IDX_W  = 3;
    localparam int unsigned MASK_W = 8;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 16;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        MEM,
        WB,
        DONE
    } lmsm_state_t;

endpackage

// File: rtl/lm_sm_seq_prio_enc.sv
// Lowest-set-bit priority encoder: idx is the position of the least
// significant set bit of req; valid is low when req is all zeros.
module lmsm_prio_enc8
    import lm_sm_seq_pkg::*;
(
    input  logic [MASK_W-1:0] req,
    output logic [IDX_W-1:0]  idx,
    output logic              valid
);

    // Scan upward and keep only the first hit.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int unsigned i = 0; i < MASK_W; i++) begin
            if (req[i] && !valid) begin
                idx   = IDX_W'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lm_sm_seq.sv
// Load/store-multiple sequencer. Walks a register bitmap in ascending
// index order, issuing one memory transfer per selected register at
// consecutive addresses spaced by ADDR_STEP.
// Optional feature: define LMSM_XFER_COUNT_EN to add the xfer_count output
// (registers completed in the current/most recent transfer).
module lm_sm_seq
    import lm_sm_seq_pkg::*;
#(
    parameter logic [ADDR_W-1:0] ADDR_STEP = 16'd1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              is_store,
    input  logic [MASK_W-1:0] mask,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              busy,
    output logic              done,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wr_data,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic [IDX_W-1:0]  rf_read_add,
    input  logic [DATA_W-1:0] rf_rd_data,
    output logic              rf_write_n,
    output logic [IDX_W-1:0]  rf_write_select,
    output logic [DATA_W-1:0] rf_wr_data
`ifdef LMSM_XFER_COUNT_EN
    ,
    output logic [CNT_W-1:0]  xfer_count
`endif
);

    lmsm_state_t       state_q, state_d;
    logic [MASK_W-1:0] rem_mask_q, rem_mask_d;
    logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
    logic              op_q, op_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;

    logic [IDX_W-1:0]  enc_idx;
    logic              enc_valid;
    logic              load_op;
    logic              advance;

    lmsm_prio_enc8 u_prio_enc (
        .req   (rem_mask_q),
        .idx   (enc_idx),
        .valid (enc_valid)
    );

    // Register update for FSM state and transfer context.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            rem_mask_q <= '0;
            cur_addr_q <= '0;
            op_q       <= 1'b0;
            idx_q      <= '0;
            wr_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            rem_mask_q <= rem_mask_d;
            cur_addr_q <= cur_addr_d;
            op_q       <= op_d;
            idx_q      <= idx_d;
            wr_data_q  <= wr_data_d;
        end
    end

    // Next-state, context updates and per-state outputs.
    always_comb begin
        state_d         = state_q;
        rem_mask_d      = rem_mask_q;
        cur_addr_d      = cur_addr_q;
        op_d            = op_q;
        idx_d           = idx_q;
        wr_data_d       = wr_data_q;
        load_op         = 1'b0;
        advance         = 1'b0;

        busy            = (state_q != IDLE);
        done            = 1'b0;
        mem_req         = 1'b0;
        mem_we          = 1'b0;
        mem_addr        = '0;
        mem_wr_data     = '0;
        rf_read_add     = '0;
        rf_write_n      = 1'b1;
        rf_write_select = '0;
        rf_wr_data      = '0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    load_op = 1'b1;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (!enc_valid) begin
                    state_d = DONE;
                end else begin
                    idx_d   = enc_idx;
                    state_d = MEM;
                end
            end
            MEM: begin
                mem_req     = 1'b1;
                mem_we      = op_q;
                mem_addr    = cur_addr_q;
                rf_read_add = idx_q;
                mem_wr_data = rf_rd_data;
                if (mem_ack) begin
                    if (op_q) begin
                        advance = 1'b1;
                        state_d = SCAN;
                    end else begin
                        wr_data_d = mem_rd_data;
                        state_d   = WB;
                    end
                end
            end
            WB: begin
                rf_write_n      = 1'b0;
                rf_write_select = idx_q;
                rf_wr_data      = wr_data_q;
                advance         = 1'b1;
                state_d         = SCAN;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A register completes either on a store ack or on its load write-back.
        if (load_op) begin
            rem_mask_d = mask;
            cur_addr_d = base_addr;
            op_d       = is_store;
        end
        if (advance) begin
            rem_mask_d[idx_q] = 1'b0;
            cur_addr_d        = cur_addr_q + ADDR_STEP;
        end
    end

`ifdef LMSM_XFER_COUNT_EN
    logic [CNT_W-1:0] cnt_q;

    // Completed-register counter, cleared on each accepted start.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (load_op) begin
            cnt_q <= '0;
        end else if (advance) begin
            cnt_q <= cnt_q + 4'd1;
        end
    end

    assign xfer_count = cnt_q;
`endif

endmodule
